// File: rtl/cshm_seq_mult.sv
// cshm_seq_mult: nibble-serial CSHM multiplier/accumulator (x * sign-magnitude coef).
// Optional macro CSHM_SAT_EN clamps the product output instead of wrapping it.
module cshm_seq_mult #(
    parameter int DATA_W = 16,
    parameter int NIB    = 2,
    parameter int OUT_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   x,
    input  logic [4*NIB:0]      coef,
    input  logic                acc_en,
    input  logic                clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    product,
    output logic                busy
);
    localparam int CW    = 4*NIB + 1;
    localparam int MW    = 4*NIB;
    localparam int XW    = DATA_W + 4;
    localparam int IW    = DATA_W + 4*NIB + 1;
    localparam int SW    = IW + 1;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SEL  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] x_r;
    logic [MW-1:0]     mag_r;
    logic              sign_r;
    logic              acc_r;
    logic [CNT_W-1:0]  cnt;
    logic [IW-1:0]     partial;
    logic [SW-1:0]     sum;
    logic [OUT_W-1:0]  product_r;
    logic [XW-1:0]     bank [8];   // bank[i] = x * (2i+1)

    logic [XW-1:0]     xe;
    logic [3:0]        nib;
    logic [XW-1:0]     sel_odd;
    logic [1:0]        sel_sh;
    logic [IW-1:0]     sel_ext;
    logic [IW-1:0]     m;
    logic [SW-1:0]     m_ext;
    logic [SW-1:0]     sum_next;
    logic [OUT_W-1:0]  prod_next;

    assign xe = {{4{x_r[DATA_W-1]}}, x_r};
    assign nib = mag_r[MW-1 -: 4];   // magnitude is shifted left each SEL cycle, MSB nibble first

    // NOTE: every variable in this block gets a default first, so no latch is inferred.
    always_comb begin
        sel_odd = '0;
        sel_sh  = 2'd0;
        case (nib)
            4'd1:  begin sel_odd = bank[0]; sel_sh = 2'd0; end
            4'd2:  begin sel_odd = bank[0]; sel_sh = 2'd1; end
            4'd3:  begin sel_odd = bank[1]; sel_sh = 2'd0; end
            4'd4:  begin sel_odd = bank[0]; sel_sh = 2'd2; end
            4'd5:  begin sel_odd = bank[2]; sel_sh = 2'd0; end
            4'd6:  begin sel_odd = bank[1]; sel_sh = 2'd1; end
            4'd7:  begin sel_odd = bank[3]; sel_sh = 2'd0; end
            4'd8:  begin sel_odd = bank[0]; sel_sh = 2'd3; end
            4'd9:  begin sel_odd = bank[4]; sel_sh = 2'd0; end
            4'd10: begin sel_odd = bank[2]; sel_sh = 2'd1; end
            4'd11: begin sel_odd = bank[5]; sel_sh = 2'd0; end
            4'd12: begin sel_odd = bank[1]; sel_sh = 2'd2; end
            4'd13: begin sel_odd = bank[6]; sel_sh = 2'd0; end
            4'd14: begin sel_odd = bank[3]; sel_sh = 2'd1; end
            4'd15: begin sel_odd = bank[7]; sel_sh = 2'd0; end
            default: begin sel_odd = '0; sel_sh = 2'd0; end
        endcase
        sel_ext  = {{(IW-XW){sel_odd[XW-1]}}, sel_odd} << sel_sh;
        m        = sign_r ? -partial : partial;
        m_ext    = {m[IW-1], m};
        sum_next = acc_r ? (sum + m_ext) : m_ext;
`ifdef CSHM_SAT_EN
        if ((&sum_next[SW-1:OUT_W-1]) || !(|sum_next[SW-1:OUT_W-1]))
            prod_next = sum_next[OUT_W-1:0];
        else if (sum_next[SW-1])
            prod_next = {1'b1, {(OUT_W-1){1'b0}}};
        else
            prod_next = {1'b0, {(OUT_W-1){1'b1}}};
`else
        prod_next = sum_next[OUT_W-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            x_r       <= '0;
            mag_r     <= '0;
            sign_r    <= 1'b0;
            acc_r     <= 1'b0;
            cnt       <= '0;
            partial   <= '0;
            sum       <= '0;
            product_r <= '0;
            // NOTE: the small odd-multiple bank is flops, not RAM, so it is cleared with the rest.
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr) sum <= '0;
                    if (in_valid) begin
                        x_r    <= x;
                        mag_r  <= coef[CW-2:0];
                        sign_r <= coef[CW-1];
                        acc_r  <= acc_en;
                        state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    bank[0] <= xe;
                    bank[1] <= (xe << 1) + xe;
                    bank[2] <= (xe << 2) + xe;
                    bank[3] <= (xe << 3) - xe;
                    bank[4] <= (xe << 3) + xe;
                    bank[5] <= (xe << 3) + (xe << 1) + xe;
                    bank[6] <= (xe << 3) + (xe << 2) + xe;
                    bank[7] <= (xe << 4) - xe;
                    cnt     <= CNT_W'(NIB - 1);
                    partial <= '0;
                    state   <= S_SEL;
                end
                S_SEL: begin
                    partial <= (partial << 4) + sel_ext;
                    mag_r   <= mag_r << 4;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIN;
                end
                S_FIN: begin
                    sum       <= sum_next;
                    product_r <= prod_next;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_OUT);
    assign product   = product_r;
endmodule

// File: tb/tb_cshm_seq_mult.sv
// Directed, table-driven bench for cshm_seq_mult (DATA_W=16, NIB=2, OUT_W=16).
// Build with +define+CSHM_SAT_EN to check the saturating product variant.
module tb_cshm_seq_mult;
    localparam int DATA_W = 16;
    localparam int NIB    = 2;
    localparam int OUT_W  = 16;
    localparam int CW     = 4*NIB + 1;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] x = '0;
    logic [CW-1:0]     coef = '0;
    logic              acc_en = 1'b0;
    logic              clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  product;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DATA_W-1:0] x;
        logic [CW-1:0]     coef;
        logic [OUT_W-1:0]  exp;
    } vec_t;

    vec_t vecs[8];

    cshm_seq_mult #(.DATA_W(DATA_W), .NIB(NIB), .OUT_W(OUT_W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .coef(coef), .acc_en(acc_en), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called and returns on a falling edge; runs one full transaction.
    task automatic run_op(input logic [DATA_W-1:0] vx, input logic [CW-1:0] vc,
                          input logic va, input logic vclr, input logic [OUT_W-1:0] exp,
                          input string tag);
        int w;
        int n;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        x = vx; coef = vc; acc_en = va; clr = vclr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " product"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        vecs[0] = '{x: 16'd3,     coef: 9'h025, exp: 16'd111};
        vecs[1] = '{x: 16'd100,   coef: 9'h1FF, exp: 16'h9C64};
        vecs[2] = '{x: 16'd7,     coef: 9'h0F0, exp: 16'h0690};
        vecs[3] = '{x: 16'd5,     coef: 9'h00C, exp: 16'd60};
        vecs[4] = '{x: 16'd123,   coef: 9'h100, exp: 16'd0};
        vecs[5] = '{x: 16'hFFFF,  coef: 9'h188, exp: 16'd136};
`ifdef CSHM_SAT_EN
        vecs[6] = '{x: 16'h7FFF,  coef: 9'h0FF, exp: 16'h7FFF};
`else
        vecs[6] = '{x: 16'h7FFF,  coef: 9'h0FF, exp: 16'h7F01};
`endif
        vecs[7] = '{x: 16'h8000,  coef: 9'h0FF, exp: 16'h8000};

        // Reset state
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst product",   32'(product),   32'd0);
        check("rst busy",      32'(busy),      32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_op(vecs[i].x, vecs[i].coef, 1'b0, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));

        // Accumulation: clr alone, then two accumulating ops, then clr with accept
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        run_op(16'd10, 9'h005, 1'b1, 1'b0, 16'd50,  "acc1");
        run_op(16'd2,  9'h103, 1'b1, 1'b0, 16'd44,  "acc2");
        run_op(16'd3,  9'h025, 1'b1, 1'b1, 16'd111, "acc_clr");

        // Backpressure: hold result while a new request is offered
        x = 16'd3; coef = 9'h025; acc_en = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("bp latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            x = 16'd9; coef = 9'h001; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d product", i),   32'(product),   32'd111);
            check($sformatf("bp%0d in_ready", i),  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp out_valid_drop", 32'(out_valid), 32'd0);
        repeat (6) @(negedge clk);
        check("bp idle busy",    32'(busy),    32'd0);
        check("bp idle product", 32'(product), 32'd111);

        // Reset during SEL aborts with no output
        x = 16'd100; coef = 9'h1FF; acc_en = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid out_valid", 32'(out_valid), 32'd0);
        check("mid product",   32'(product),   32'd0);
        check("mid busy",      32'(busy),      32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid no_output", 32'(seen), 32'd0);
        check("mid in_ready",  32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
